// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register slice.
package if_id_pkg;

  localparam int unsigned RV_NOP_W = 32;
  localparam logic [RV_NOP_W-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register: main + skid buffer so every output is a flop,
// with flush-to-bubble and a back-pressure cycle counter.
module if_id_pipe_stage
  import if_id_pkg::*;
#(
  parameter int unsigned       PC_W         = 32,
  parameter int unsigned       INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(RV_NOP),
  parameter int unsigned       CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  if_id_state_e       r_state;
  if_id_state_e       w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    w_main_pc_nxt;
  logic [INSTR_W-1:0] w_main_instr_nxt;
  logic [PC_W-1:0]    w_skid_pc_nxt;
  logic [INSTR_W-1:0] w_skid_instr_nxt;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_stall_inc;

  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_stall_inc = r_out_valid & ~out_ready;

  // Next-state and datapath selection; flush overrides every handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_pc_nxt    = r_main_pc;
    w_main_instr_nxt = r_main_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_main_pc_nxt    = '0;
      w_main_instr_nxt = BUBBLE_INSTR;
      w_skid_pc_nxt    = '0;
      w_skid_instr_nxt = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt      = ONE;
            w_main_pc_nxt    = in_pc;
            w_main_instr_nxt = in_instr;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_pc_nxt    = in_pc;
            w_main_instr_nxt = in_instr;
          end else if (w_in_fire) begin
            w_state_nxt      = TWO;
            w_skid_pc_nxt    = in_pc;
            w_skid_instr_nxt = in_instr;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = ONE;
            w_main_pc_nxt    = r_skid_pc;
            w_main_instr_nxt = r_skid_instr;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state to keep outputs flop-driven.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= EMPTY;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_main_pc    <= '0;
      r_main_instr <= BUBBLE_INSTR;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_in_ready   <= (w_state_nxt != TWO);
      r_out_valid  <= (w_state_nxt != EMPTY);
      r_main_pc    <= w_main_pc_nxt;
      r_main_instr <= w_main_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_main_pc;
  assign out_instr = r_main_instr;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed + random bench for if_id_pipe_stage using a queue scoreboard.
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready,  out_valid;
  logic [31:0] out_pc,    out_instr;
  logic [15:0] stall_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2,   out_instr2;
  logic [1:0]  stall_cnt2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  int unsigned m_stall;
  int unsigned m_stall2;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  if_id_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .stall_cnt (stall_cnt)
  );

  if_id_pipe_stage #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_pc    (out_pc2),
    .out_instr (out_instr2),
    .stall_cnt (stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at negedge, advance the model, then step past posedge.
  task automatic cycle(input bit do_chk);
    bit fire_in, fire_out;
    @(negedge clk);
    if (do_chk) begin
      chk("out_valid",  64'(out_valid),  64'(q.size() > 0));
      chk("in_ready",   64'(in_ready),   64'(q.size() < 2));
      chk("out_pc",     64'(out_pc),     64'(exp_pc));
      chk("out_instr",  64'(out_instr),  64'(exp_instr));
      chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
      chk("out_pc2",    64'(out_pc2),    64'(exp_pc));
      chk("stall_cnt2", 64'(stall_cnt2), 64'(m_stall2));
    end
    if (!rst) begin
      q.delete();
      exp_pc    = 32'h0;
      exp_instr = NOP;
      m_stall   = 0;
      m_stall2  = 0;
    end else begin
      if (q.size() > 0 && !out_ready) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
      if (flush) begin
        q.delete();
        exp_pc    = 32'h0;
        exp_instr = NOP;
      end else begin
        fire_out = (q.size() > 0) && out_ready;
        fire_in  = in_valid && (q.size() < 2);
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back({in_pc, in_instr});
        if (q.size() > 0) begin
          exp_pc    = q[0].pc;
          exp_instr = q[0].instr;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    exp_pc = 32'h0; exp_instr = NOP; m_stall = 0; m_stall2 = 0;
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);

    // single push, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h0050_0093);
    cycle(1'b1);
    drive(1'b0, 32'h0, 32'h0);
    cycle(1'b1);
    chk("lat_pc", 64'(out_pc), 64'h100);
    cycle(1'b1);

    // fill to TWO under back-pressure, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h0000_0200);
    cycle(1'b1);
    drive(1'b1, 32'h204, 32'h0000_0204);
    cycle(1'b1);
    drive(1'b1, 32'h2FF, 32'h0000_02FF);
    cycle(1'b1);
    chk("two_in_ready", 64'(in_ready), 64'h0);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) cycle(1'b1);

    // flush in TWO discards held entries and the coincident push
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h0000_0300);
    cycle(1'b1);
    drive(1'b1, 32'h304, 32'h0000_0304);
    cycle(1'b1);
    flush = 1'b1;
    drive(1'b1, 32'h308, 32'h0000_0308);
    cycle(1'b1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_instr", 64'(out_instr), 64'(NOP));
    repeat (2) cycle(1'b1);

    // stall counting, flush-with-ready keeps count, narrow counter saturates
    rst = 1'b0;
    cycle(1'b1);
    rst = 1'b1;
    drive(1'b1, 32'h500, 32'h0000_0500);
    cycle(1'b1);
    drive(1'b0, 32'h0, 32'h0);
    repeat (5) cycle(1'b1);
    chk("stall5", 64'(stall_cnt), 64'd5);
    flush = 1'b1; out_ready = 1'b1;
    cycle(1'b1);
    flush = 1'b0; out_ready = 1'b0;
    cycle(1'b1);
    chk("stall_after_flush", 64'(stall_cnt), 64'd5);
    drive(1'b1, 32'h504, 32'h0000_0504);
    cycle(1'b1);
    drive(1'b0, 32'h0, 32'h0);
    cycle(1'b1);
    chk("stall2_sat", 64'(stall_cnt2), 64'd3);

    // reset and flush together while in TWO
    drive(1'b1, 32'h600, 32'h0000_0600);
    cycle(1'b1);
    chk("pre_rst_two", 64'(in_ready), 64'h0);
    rst = 1'b0; flush = 1'b1;
    cycle(1'b1);
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    drive(1'b1, 32'h400, 32'h0000_0400);
    cycle(1'b1);
    drive(1'b0, 32'h0, 32'h0);
    cycle(1'b1);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      cycle(1'b1);
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_stage.md
IF_ID_PIPE_STAGE -- requirements
Module: if_id_pipe_stage

Interface
REQ-001 Parameter PC_W, default 32, width of the PC field.
REQ-002 Parameter INSTR_W, default 32, width of the instruction field.
REQ-003 Parameter BUBBLE_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction value presented on flush or reset.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-007 flush  input  1  discard all held entries.
REQ-008 in_valid  input  1  upstream fetch entry valid.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_pc  input  PC_W  fetched PC.
REQ-011 in_instr  input  INSTR_W  fetched instruction.
REQ-012 out_valid  output  1  decode-side entry valid.
REQ-013 out_ready  input  1  decode accepts the entry this cycle.
REQ-014 out_pc  output  PC_W  registered PC to decode.
REQ-015 out_instr  output  INSTR_W  registered instruction to decode.
REQ-016 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 Storage: one main register (drives outputs) and one skid register; all outputs come straight from flops, with no combinational path from any input to any output.
REQ-019 States: EMPTY (none held), ONE (main valid, skid empty), TWO (main and skid valid).
REQ-020 in_ready = 1 in EMPTY and ONE, 0 in TWO; out_valid = 1 in ONE and TWO.
REQ-021 EMPTY: in_fire -> ONE with main <= in; otherwise stay.
REQ-022 ONE: in_fire & out_fire -> ONE with main <= in; in_fire only -> TWO with skid <= in; out_fire only -> EMPTY; neither -> hold.
REQ-023 TWO: out_fire -> ONE with main <= skid; otherwise hold (no input accepted).
REQ-024 Latency: entry accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 when the stage was EMPTY, or ONE with a simultaneous out_fire.
REQ-025 Ordering: entries leave strictly in acceptance order; no entry duplicated or dropped except by flush.
REQ-026 flush=1 has priority over all handshakes: next state EMPTY, skid discarded, any in_fire that cycle discarded, out_pc <= 0, out_instr <= BUBBLE_INSTR.
REQ-027 While out_valid=0, out_pc and out_instr hold their last value: the bubble values after flush or reset, otherwise the last popped entry.
REQ-028 stall_cnt increments by 1 each cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, and is not cleared by flush.
REQ-029 flush coincident with out_ready=1 still counts as a delivered entry for out_fire in that cycle; the stall count does not increment.

Reset
REQ-030 rst=0 at a rising clk: state EMPTY, out_valid=0, in_ready=1, out_pc=0, out_instr=BUBBLE_INSTR, skid cleared to 0, stall_cnt=0.
REQ-031 Reset dominates flush and all handshakes, including reset asserted mid-transfer in state TWO.

Structure
REQ-032 Shared package if_id_pkg holds the state enum (EMPTY/ONE/TWO) and the constant RV_NOP = 32'h0000_0013, which is the default for BUBBLE_INSTR.
REQ-033 One sub-module, sat_counter (parameter CNT_W; ports: inc, count), implements stall_cnt; all other logic is local.

Verification
REQ-034 Reset then in_valid=1, pc=0x100, instr=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093.
REQ-035 out_ready=0, push pc=0x200 then 0x204 -> state TWO, in_ready=0, out_pc=0x200; raise out_ready -> 0x200 then 0x204 delivered in order, in_ready returns to 1.
REQ-036 State TWO (0x300, 0x304), flush=1 with in_valid=1 pc=0x308 -> next cycle out_valid=0, out_pc=0, out_instr=0x00000013; 0x308 never appears.
REQ-037 Hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; apply flush -> still 5; with CNT_W=2 and 6 stall cycles -> stall_cnt=3.
REQ-038 rst=0 and flush=1 in the same cycle while in TWO -> reset values of REQ-030; the first push after reset (pc=0x400) appears one cycle later.
